// File: rtl/regfile_wb_scheduler_if.sv
// Purpose: bundles the issue, write-back request and register-file write
//          signals of the write-back scheduler into one connection.
// Ports:   master = decode + requesters + register file side,
//          slave = the scheduler itself.
interface regfile_wb_scheduler_if;
  // issue side (decode)
  logic        issue_valid;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic [4:0]  issue_rd;
  logic        issue_stall;

  // write-back requester A (ALU)
  logic        a_valid;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        a_ready;

  // write-back requester B (load unit)
  logic        b_valid;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic        b_ready;

  // register file write port and scoreboard view
  logic        rf_rWrite;
  logic [4:0]  rf_rsWrite;
  logic [31:0] rf_dataWrite;
  logic [31:0] busy;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd,
    output a_valid, a_rd, a_data,
    output b_valid, b_rd, b_data,
    input  issue_stall, a_ready, b_ready,
    input  rf_rWrite, rf_rsWrite, rf_dataWrite, busy
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd,
    input  a_valid, a_rd, a_data,
    input  b_valid, b_rd, b_data,
    output issue_stall, a_ready, b_ready,
    output rf_rWrite, rf_rsWrite, rf_dataWrite, busy
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Purpose: arbitrates ALU/load write-backs onto the single register-file write port and keeps a busy scoreboard.
// Latency: grant is combinational; write port registered (1 cycle); busy bit clears one edge after the handshake.
// Backpressure: one grant per cycle; a losing requester holds valid until granted; issue stalls on RAW/WAW hazards.
//
// Ports:
//   clk, reset  - clock (rising edge) and synchronous active-high reset
//   bus (slave) - issue_* / issue_stall, a_* and b_* valid-ready write-back
//                 requests, rf_rWrite/rf_rsWrite/rf_dataWrite to the
//                 register file, busy scoreboard (bit 0 always 0)
// Build option:
//   WB_RR_ARB_EN - when defined, A/B conflicts are resolved round-robin;
//                  otherwise A has fixed priority.
module regfile_wb_scheduler (
  input logic                   clk,
  input logic                   reset,
  regfile_wb_scheduler_if.slave bus
);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_req_t;

  wb_req_t     req_a;
  wb_req_t     req_b;
  wb_req_t     win;
  logic        grant_a;
  logic        grant_b;
  logic        hs;
  logic        issue_acc;

  logic [31:0] busy_q;
  logic [31:0] busy_d;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;

  logic        rf_we_q;
  logic [4:0]  rf_rs_q;
  logic [31:0] rf_data_q;

  // Destination of the write the register file commits at the next edge.
  logic        pend_vld;
  logic [4:0]  pend_rd;

  assign req_a = {bus.a_rd, bus.a_data};
  assign req_b = {bus.b_rd, bus.b_data};

`ifdef WB_RR_ARB_EN
  // 1 = B is preferred on the next conflict.
  logic prefer_b;

  assign grant_a = ~reset & bus.a_valid & (~bus.b_valid | ~prefer_b);
  assign grant_b = ~reset & bus.b_valid & (~bus.a_valid | prefer_b);

  // After any handshake the other requester becomes preferred.
  always_ff @(posedge clk) begin
    if (reset) begin
      prefer_b <= 1'b0;
    end else if (hs) begin
      prefer_b <= grant_a;
    end
  end
`else
  assign grant_a = ~reset & bus.a_valid;
  assign grant_b = ~reset & bus.b_valid & ~bus.a_valid;
`endif

  assign hs          = grant_a | grant_b;
  assign win         = grant_a ? req_a : req_b;
  assign bus.a_ready = grant_a;
  assign bus.b_ready = grant_b;

  assign bus.issue_stall = ~reset & bus.issue_valid &
                           (busy_q[bus.issue_rs1] | busy_q[bus.issue_rs2] | busy_q[bus.issue_rd]);
  assign issue_acc       = bus.issue_valid & ~bus.issue_stall;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_acc && (bus.issue_rd != 5'd0)) begin
      set_mask = 32'd1 << bus.issue_rd;
    end
    if (pend_vld) begin
      clr_mask = 32'd1 << pend_rd;
    end
    // Set is applied after clear so it wins if both hit one register.
    busy_d = ((busy_q & ~clr_mask) | set_mask) & ~32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q    <= '0;
      rf_we_q   <= 1'b0;
      rf_rs_q   <= '0;
      rf_data_q <= '0;
      pend_vld  <= 1'b0;
      pend_rd   <= '0;
    end else begin
      busy_q   <= busy_d;
      rf_we_q  <= hs & (win.rd != 5'd0);
      pend_vld <= hs;
      if (hs) begin
        rf_rs_q   <= win.rd;
        rf_data_q <= win.data;
        pend_rd   <= win.rd;
      end
    end
  end

  assign bus.rf_rWrite    = rf_we_q;
  assign bus.rf_rsWrite   = rf_rs_q;
  assign bus.rf_dataWrite = rf_data_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
module tb_regfile_wb_scheduler;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  regfile_wb_scheduler_if bus();

  regfile_wb_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef WB_RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: set of pending registers, writes awaiting commit,
  // arbitration preference and the expected register-file port contents.
  bit          m_busy [32];
  int          m_clear_q[$];
  bit          m_pref_b;
  bit          m_we;
  logic [4:0]  m_rs;
  logic [31:0] m_data;
  bit          got_a;
  bit          got_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_busy_vec();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // One clock cycle: check combinational outputs against the model,
  // advance the model at the edge, then check the registered outputs.
  task automatic tick();
    bit e_stall, ea, eb;
    logic [4:0]  wrd;
    logic [31:0] wdat;
    #1;
    e_stall = !reset && bus.issue_valid &&
              (m_busy[bus.issue_rs1] || m_busy[bus.issue_rs2] || m_busy[bus.issue_rd]);
    ea = 1'b0;
    eb = 1'b0;
    if (!reset) begin
      if (bus.a_valid && bus.b_valid) begin
        if (RR && m_pref_b) eb = 1'b1;
        else ea = 1'b1;
      end else begin
        ea = bus.a_valid;
        eb = bus.b_valid;
      end
    end
    chk("issue_stall", 32'(bus.issue_stall), 32'(e_stall));
    chk("a_ready", 32'(bus.a_ready), 32'(ea));
    chk("b_ready", 32'(bus.b_ready), 32'(eb));
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      m_clear_q.delete();
      m_pref_b = 1'b0;
      m_we     = 1'b0;
      m_rs     = '0;
      m_data   = '0;
    end else begin
      while (m_clear_q.size() > 0) m_busy[m_clear_q.pop_front()] = 1'b0;
      if (bus.issue_valid && !e_stall && bus.issue_rd != 5'd0) m_busy[bus.issue_rd] = 1'b1;
      if (ea || eb) begin
        wrd    = ea ? bus.a_rd : bus.b_rd;
        wdat   = ea ? bus.a_data : bus.b_data;
        m_we   = (wrd != 5'd0);
        m_rs   = wrd;
        m_data = wdat;
        m_clear_q.push_back(int'(wrd));
        m_pref_b = ea;
      end else begin
        m_we = 1'b0;
      end
    end
    got_a = ea;
    got_b = eb;
    #1;
    chk("rf_rWrite", 32'(bus.rf_rWrite), 32'(m_we));
    chk("rf_rsWrite", 32'(bus.rf_rsWrite), 32'(m_rs));
    chk("rf_dataWrite", bus.rf_dataWrite, m_data);
    chk("busy", bus.busy, model_busy_vec());
  endtask

  task automatic set_issue(input bit v, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    bus.issue_valid = v;
    bus.issue_rs1   = rs1;
    bus.issue_rs2   = rs2;
    bus.issue_rd    = rd;
  endtask

  initial begin
    reset = 1'b1;
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);
    bus.a_valid = 1'b1; bus.a_rd = 5'd3; bus.a_data = 32'hA;
    bus.b_valid = 1'b1; bus.b_rd = 5'd4; bus.b_data = 32'hB;

    // Reset held two cycles with both requesters valid.
    tick();
    tick();
    chk("rst_busy", bus.busy, 32'd0);
    chk("rst_rwrite", 32'(bus.rf_rWrite), 32'd0);
    chk("rst_data", bus.rf_dataWrite, 32'd0);

    // Release: A first, then conflict resolution.
    reset = 1'b0;
    tick();
    chk("conf1_granted_a", 32'(got_a), 32'd1);
    chk("conf1_rs", 32'(bus.rf_rsWrite), 32'd3);
    chk("conf1_data", bus.rf_dataWrite, 32'hA);
    tick();
    chk("conf2_rs", 32'(bus.rf_rsWrite), RR ? 32'd4 : 32'd3);
    chk("conf2_data", bus.rf_dataWrite, RR ? 32'hB : 32'hA);
    if (got_a) bus.a_valid = 1'b0;
    if (got_b) bus.b_valid = 1'b0;
    tick();
    chk("conf3_rs", 32'(bus.rf_rsWrite), RR ? 32'd3 : 32'd4);
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;

    // RAW on x5.
    set_issue(1'b1, 5'd0, 5'd0, 5'd5);
    tick();
    chk("raw_busy5_set", 32'(bus.busy[5]), 32'd1);
    set_issue(1'b1, 5'd5, 5'd0, 5'd0);
    tick();
    chk("raw_stall_a", 32'(bus.issue_stall), 32'd1);
    bus.a_valid = 1'b1; bus.a_rd = 5'd5; bus.a_data = 32'h1234;
    tick();
    chk("raw_we", 32'(bus.rf_rWrite), 32'd1);
    chk("raw_rs", 32'(bus.rf_rsWrite), 32'd5);
    chk("raw_data", bus.rf_dataWrite, 32'h1234);
    chk("raw_busy5_hold", 32'(bus.busy[5]), 32'd1);
    bus.a_valid = 1'b0;
    tick();
    chk("raw_busy5_clr", 32'(bus.busy[5]), 32'd0);
    #1;
    chk("raw_stall_drop", 32'(bus.issue_stall), 32'd0);
    tick();
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);

    // x0: no scoreboard entry, handshake consumed without a write.
    set_issue(1'b1, 5'd0, 5'd0, 5'd0);
    tick();
    chk("x0_busy", bus.busy, 32'd0);
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);
    bus.a_valid = 1'b1; bus.a_rd = 5'd0; bus.a_data = 32'hFFFF;
    tick();
    chk("x0_hs", 32'(got_a), 32'd1);
    chk("x0_we", 32'(bus.rf_rWrite), 32'd0);
    bus.a_valid = 1'b0;
    tick();
    chk("x0_busy_after", bus.busy, 32'd0);

    // WAW on x29.
    set_issue(1'b1, 5'd0, 5'd0, 5'd29);
    tick();
    tick();
    chk("waw_stall", 32'(bus.issue_stall), 32'd1);
    bus.b_valid = 1'b1; bus.b_rd = 5'd29; bus.b_data = 32'h29;
    tick();
    chk("waw_stall_hs", 32'(bus.issue_stall), 32'd1);
    bus.b_valid = 1'b0;
    tick();
    chk("waw_busy_clr", 32'(bus.busy[29]), 32'd0);
    tick();
    chk("waw_reissue", 32'(bus.busy[29]), 32'd1);
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);

    // Reset the cycle after a B handshake on x7.
    set_issue(1'b1, 5'd0, 5'd0, 5'd7);
    tick();
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);
    bus.b_valid = 1'b1; bus.b_rd = 5'd7; bus.b_data = 32'h77;
    tick();
    chk("mid_hs_we", 32'(bus.rf_rWrite), 32'd1);
    bus.b_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("mid_we", 32'(bus.rf_rWrite), 32'd0);
    chk("mid_busy7", 32'(bus.busy[7]), 32'd0);
    reset = 1'b0;
    tick();

    // Randomized traffic with holding requesters and occasional reset.
    for (int n = 0; n < 3000; n++) begin
      set_issue(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      if (!bus.a_valid && $urandom_range(0, 2) != 0) begin
        bus.a_valid = 1'b1;
        bus.a_rd    = 5'($urandom_range(0, 7));
        bus.a_data  = $urandom;
      end
      if (!bus.b_valid && $urandom_range(0, 2) != 0) begin
        bus.b_valid = 1'b1;
        bus.b_rd    = 5'($urandom_range(0, 7));
        bus.b_data  = $urandom;
      end
      reset = ($urandom_range(0, 199) == 0);
      tick();
      if (got_a) bus.a_valid = 1'b0;
      if (got_b) bus.b_valid = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Write-back scheduler and scoreboard for the 32×32 register file. It arbitrates two write-back requesters, the ALU (A) and the load unit (B), onto the register file's single write port (`rWrite`/`rsWrite`/`dataWrite`). It tracks pending destination registers in a busy scoreboard. It stalls issue on RAW or WAW hazards until the register file has committed the value.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  reset, synchronous, active-high
- `issue_valid`  in  1  decode presents an instruction this cycle
- `issue_rs1`  in  5  source register 1 of the issuing instruction
- `issue_rs2`  in  5  source register 2 of the issuing instruction
- `issue_rd`  in  5  destination register; 0 means no write-back expected
- `issue_stall`  out  1  combinational; issue is not accepted this cycle
- `a_valid`  in  1  ALU write-back request
- `a_rd`  in  5  ALU destination
- `a_data`  in  32  ALU result
- `a_ready`  out  1  combinational grant to A
- `b_valid`, `b_rd`, `b_data`, `b_ready`  same as A, for the load unit
- `rf_rWrite`  out  1  registered; to register file `rWrite`
- `rf_rsWrite`  out  5  registered; to register file `rsWrite`
- `rf_dataWrite`  out  32  registered; to register file `dataWrite`
- `busy`  out  32  scoreboard; bit n set means register n has a pending write

## Operation
- **Scoreboard**
  - `issue_stall = issue_valid & (busy[issue_rs1] | busy[issue_rs2] | busy[issue_rd])`.
  - Accepted issue is `issue_valid & ~issue_stall`.
  - On accepted issue with `issue_rd != 0`, `busy[issue_rd]` is set at the edge.
  - `busy[0]` is constantly 0.
- **Arbitration**
  - One grant per cycle; `a_ready`/`b_ready` are never both 1.
  - A handshake completes when `valid & ready` is sampled at a rising edge.
  - Requesters hold `valid`/`rd`/`data` stable until granted.
  - Ready depends only on the valids and the priority state, never on `data`.
  - Only one requester valid: that requester is granted.
  - Both valid: the priority rule applies (see Configuration).
- **Write port**
  - At the handshake edge, the granted `rd`/`data` are loaded into `rf_rsWrite`/`rf_dataWrite`.
  - At the same edge, `rf_rWrite` is set to 1 if `rd != 0`, else 0.
  - With no handshake, `rf_rWrite` is loaded with 0 and `rf_rsWrite`/`rf_dataWrite` hold their values.
- **Busy clear**
  - The granted `rd` is held in a pending-clear register.
  - `busy[rd]` clears at the edge following the handshake, which is the edge where the register file commits the write.
  - An issue sampled in the cycle after that edge reads the new value through the register file's registered read.
- **Boundaries**
  - Write-back to a non-busy register is still written and clears nothing.
  - A handshake with `rd == 0` is consumed with no register file write.
  - Set and clear of the same register in one cycle cannot occur: a busy `issue_rd` stalls issue (WAW).
  - If it is forced, set wins.

## Timing
- **Grant latency:** 0 cycles; ready is combinational from the valids.
- **Handshake to write:** handshake at edge E0 gives `rf_rWrite` = 1 during cycle E0→E1. The register file writes at E1.
- **Handshake to busy clear:** `busy` bit clears at E1. `issue_stall` for that hazard drops in cycle E1→E2.
- **Throughput:** one write-back per cycle, back-to-back.
- **Reset values:**
  - `busy` = 0, `rf_rWrite` = 0, `rf_rsWrite` = 0, `rf_dataWrite` = 0.
  - Pending-clear register cleared; priority pointer set to A.
  - `a_ready` = `b_ready` = 0 and `issue_stall` = 0 while `reset` is high.
- **Reset mid-operation:** in-flight grant and pending clear are discarded. Any request still valid after reset is re-arbitrated.

## Configuration
- **`WB_RR_ARB_EN` defined:** round-robin.
  - A 1-bit pointer names the preferred requester.
  - On a handshake with both valid, the pointer moves to the loser.
  - On a single-requester handshake, the pointer moves to the other requester.
  - Reset value is A.
- **Not defined:** fixed priority, A always wins a conflict. The pointer logic is absent. B may starve while A is continuously valid.

## Test plan
- **Reset:**
  - Stimulus: hold reset 2 cycles with `a_valid` = `b_valid` = 1.
  - Response: all outputs 0 during reset. After release, A is granted first; `rf_rsWrite`/`rf_dataWrite` take A's values one cycle later.
- **RAW hazard:**
  - Stimulus: issue rd = 5; next cycle issue rs1 = 5. A writes x5 = 0x1234 two cycles later.
  - Response: `busy[5]` = 1 and `issue_stall` = 1 until the edge after the handshake. `rf_rWrite` = 1 with `rsWrite` = 5 and `data` = 0x1234; the stall drops the following cycle.
- **Conflict:**
  - Stimulus: A (rd = 3, 0xA) and B (rd = 4, 0xB) both valid for 2 cycles.
  - Response with `WB_RR_ARB_EN`: A then B.
  - Response without it: A twice if A re-requests, and B waits.
- **x0:**
  - Stimulus: issue rd = 0, then A writes rd = 0, data 0xFFFF.
  - Response: `busy` stays 0, handshake completes, `rf_rWrite` stays 0.
- **WAW:**
  - Stimulus: issue rd = 29 while `busy[29]` = 1.
  - Response: `issue_stall` = 1 until the write-back to x29 commits.
- **Mid-flight reset:**
  - Stimulus: assert reset the cycle after a B handshake (rd = 7).
  - Response: `rf_rWrite` = 0 and `busy[7]` = 0 after the reset edge.
